// File: rtl/spi_flash_rd_ctrl.sv
// Single-word SPI flash read controller (mode 0) for the cv32e40x boot/data flash.
// Define SPI_FLASH_FASTREAD_EN to use FAST READ (0Bh) with 8 dummy clocks after the address.
module spi_flash_rd_ctrl #(
  parameter int unsigned CLK_DIV     = 2,
  parameter logic [23:0] ADDR_OFFSET = 24'h200000,
  parameter int unsigned CS_HIGH_MIN = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [23:0] addr_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        sck_o,
  output logic        sdo_o,
  input  logic        sdi_i,
  output logic        cs_o
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_CMD,
    SHIFT_ADDR,
`ifdef SPI_FLASH_FASTREAD_EN
    DUMMY,
`endif
    SHIFT_DATA,
    DONE,
    GAP
  } state_t;

`ifdef SPI_FLASH_FASTREAD_EN
  localparam logic [7:0] OPCODE     = 8'h0B;
  localparam logic [6:0] LAST_BIT   = 7'd71;
  localparam state_t     AFTER_ADDR = DUMMY;
`else
  localparam logic [7:0] OPCODE     = 8'h03;
  localparam logic [6:0] LAST_BIT   = 7'd63;
  localparam state_t     AFTER_ADDR = SHIFT_DATA;
`endif
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_HIGH_MIN - 1);

  state_t      state_r;
  state_t      next_phase_s;
  logic        ready_r;
  logic        cs_r;
  logic        sck_r;
  logic        sdo_r;
  logic        rvalid_r;
  logic [31:0] rdata_r;
  logic [31:0] tx_sr_r;
  logic [31:0] rx_sr_r;
  logic [6:0]  bit_cnt_r;
  logic [15:0] div_cnt_r;
  logic [15:0] gap_cnt_r;
  logic [23:0] phys_addr_s;

  // Bytes arrive in address order; the first byte is the least significant.
  function automatic logic [31:0] le_word(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

  assign phys_addr_s = (addr_i & 24'hFFFFFC) + ADDR_OFFSET;

  assign ready_o  = ready_r;
  assign rdata_o  = rdata_r;
  assign rvalid_o = rvalid_r;
  assign sck_o    = sck_r;
  assign sdo_o    = sdo_r;
  assign cs_o     = cs_r;

  // Phase to enter after the falling SCK edge that completes the current bit.
  always_comb begin
    next_phase_s = state_r;
    case (state_r)
      SHIFT_CMD: begin
        if (bit_cnt_r == 7'd7) next_phase_s = SHIFT_ADDR;
        else                   next_phase_s = SHIFT_CMD;
      end
      SHIFT_ADDR: begin
        if (bit_cnt_r == 7'd31) next_phase_s = AFTER_ADDR;
        else                    next_phase_s = SHIFT_ADDR;
      end
`ifdef SPI_FLASH_FASTREAD_EN
      DUMMY: begin
        if (bit_cnt_r == 7'd39) next_phase_s = SHIFT_DATA;
        else                    next_phase_s = DUMMY;
      end
`endif
      default: next_phase_s = state_r;
    endcase
  end

  // Transaction FSM with the SCK divider, shift registers and all pad outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      cs_r      <= 1'b1;
      sck_r     <= 1'b0;
      sdo_r     <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      tx_sr_r   <= 32'd0;
      rx_sr_r   <= 32'd0;
      bit_cnt_r <= 7'd0;
      div_cnt_r <= 16'd0;
      gap_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_i && ready_r) begin
            tx_sr_r   <= {OPCODE, phys_addr_s};
            sdo_r     <= OPCODE[7];
            cs_r      <= 1'b0;
            ready_r   <= 1'b0;
            bit_cnt_r <= 7'd0;
            div_cnt_r <= 16'd0;
            state_r   <= SHIFT_CMD;
          end else begin
            state_r <= IDLE;
          end
        end
`ifdef SPI_FLASH_FASTREAD_EN
        SHIFT_CMD, SHIFT_ADDR, DUMMY, SHIFT_DATA: begin
`else
        SHIFT_CMD, SHIFT_ADDR, SHIFT_DATA: begin
`endif
          if (div_cnt_r != DIV_LAST) begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end else begin
            div_cnt_r <= 16'd0;
            if (!sck_r) begin
              sck_r <= 1'b1;
              if (state_r == SHIFT_DATA) rx_sr_r <= {rx_sr_r[30:0], sdi_i};
              else                       rx_sr_r <= rx_sr_r;
            end else begin
              // Falling edge: the next MOSI bit launches on this same clk edge.
              sck_r     <= 1'b0;
              bit_cnt_r <= bit_cnt_r + 7'd1;
              tx_sr_r   <= {tx_sr_r[30:0], 1'b0};
              sdo_r     <= tx_sr_r[30];
              if (bit_cnt_r == LAST_BIT) begin
                cs_r      <= 1'b1;
                rvalid_r  <= 1'b1;
                rdata_r   <= le_word(rx_sr_r);
                gap_cnt_r <= 16'd0;
                state_r   <= DONE;
              end else begin
                state_r <= next_phase_s;
              end
            end
          end
        end
        DONE, GAP: begin
          rvalid_r <= 1'b0;
          if (gap_cnt_r == GAP_LAST) begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + 16'd1;
            state_r   <= GAP;
          end
        end
        default: begin
          state_r  <= IDLE;
          ready_r  <= 1'b1;
          cs_r     <= 1'b1;
          sck_r    <= 1'b0;
          sdo_r    <= 1'b0;
          rvalid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Scoreboard bench for spi_flash_rd_ctrl with a behavioural SPI flash model on the pads.
module tb_spi_flash_rd_ctrl;

  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned CS_HIGH_MIN = 2;
`ifdef SPI_FLASH_FASTREAD_EN
  localparam logic [7:0] OPC   = 8'h0B;
  localparam int         HDR   = 40;
  localparam int         NBITS = 72;
  localparam int         LAT   = 289;
`else
  localparam logic [7:0] OPC   = 8'h03;
  localparam int         HDR   = 32;
  localparam int         NBITS = 64;
  localparam int         LAT   = 257;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [23:0] addr_i = 24'd0;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        sck_o;
  logic        sdo_o;
  logic        sdi_i = 1'b0;
  logic        cs_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] word;
    logic [23:0] phys;
  } exp_t;
  exp_t exp_q[$];

  spi_flash_rd_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .ADDR_OFFSET(24'h200000),
    .CS_HIGH_MIN(CS_HIGH_MIN)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .addr_i  (addr_i),
    .ready_o (ready_o),
    .rdata_o (rdata_o),
    .rvalid_o(rvalid_o),
    .sck_o   (sck_o),
    .sdo_o   (sdo_o),
    .sdi_i   (sdi_i),
    .cs_o    (cs_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h200010: return 8'h11;
      24'h200011: return 8'h22;
      24'h200012: return 8'h33;
      24'h200013: return 8'h44;
      default:    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [23:0] phys_of(input logic [23:0] a);
    logic [23:0] m;
    m = a & 24'hFFFFFC;
    return m + 24'h200000;
  endfunction

  function automatic logic [31:0] word_at(input logic [23:0] p);
    return {flash_byte(p + 24'd3), flash_byte(p + 24'd2), flash_byte(p + 24'd1), flash_byte(p)};
  endfunction

  // Flash model: capture MOSI on SCK rise, launch MISO on SCK fall.
  int          rise_cnt     = 0;
  int          last_rises   = 0;
  int          sck_hi_edges = 0;
  logic [31:0] hdr_cap      = 32'd0;
  logic [7:0]  dummy_cap    = 8'd0;

  always @(posedge sck_o) begin
    if (!cs_o) begin
      if (rise_cnt < 32) hdr_cap = {hdr_cap[30:0], sdo_o};
      else if (rise_cnt < HDR) dummy_cap = {dummy_cap[6:0], sdo_o};
      rise_cnt = rise_cnt + 1;
    end else begin
      sck_hi_edges = sck_hi_edges + 1;
    end
  end

  always @(posedge cs_o) begin
    last_rises = rise_cnt;
    rise_cnt   = 0;
  end

  always @(negedge sck_o) begin
    if (!cs_o && rise_cnt >= HDR && rise_cnt < HDR + 32) begin
      int         idx;
      logic [7:0] b;
      idx   = rise_cnt - HDR;
      b     = flash_byte(hdr_cap[23:0] + 24'(idx / 8));
      sdi_i = b[7 - (idx % 8)];
    end
  end

  task automatic issue(input logic [23:0] a);
    exp_t e;
    e.phys = phys_of(a);
    e.word = word_at(e.phys);
    exp_q.push_back(e);
    req_i  = 1'b1;
    addr_i = a;
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.word = 32'hDEADBEEF;
      e.phys = 24'hDEAD00;
    end
  endtask

  task automatic wait_rvalid(output int cycles);
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_i); #1;
      cycles++;
      if (rvalid_o) break;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    n_tests++;
    if ({cs_o, sck_o, sdo_o, rvalid_o, ready_o} !== 5'b10001) begin
      n_fail++;
      $display("FAIL reset_pads: cs,sck,sdo,rvalid,ready=%b expected 10001", {cs_o, sck_o, sdo_o, rvalid_o, ready_o});
    end
    n_tests++;
    if (rdata_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 00000000", rdata_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    n_tests++;
    if ({cs_o, ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_idle: cs,ready=%b expected 11", {cs_o, ready_o});
    end
  endtask

  task automatic test_basic_read();
    exp_t e;
    int   lat;
    int   cyc;
    int   extra;
    logic [7:0] opc_v;
    opc_v = OPC;
    issue(24'h000010);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    lat = 1;
    n_tests++;
    if ({cs_o, ready_o, sdo_o} !== {1'b0, 1'b0, opc_v[7]}) begin
      n_fail++;
      $display("FAIL basic_start: cs,ready,sdo=%b expected %b", {cs_o, ready_o, sdo_o}, {1'b0, 1'b0, opc_v[7]});
    end
    @(posedge clk_i); #1; lat++;
    n_tests++;
    if (sck_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sck_low: got %b expected 0", sck_o);
    end
    @(posedge clk_i); #1; lat++;
    n_tests++;
    if (sck_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_sck_rise: got %b expected 1", sck_o);
    end
    wait_rvalid(cyc);
    lat += cyc;
    n_tests++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
    end
    n_tests++;
    if ({rvalid_o, cs_o, sck_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL basic_end_edge: rvalid,cs,sck=%b expected 110", {rvalid_o, cs_o, sck_o});
    end
    pop_exp(e);
    n_tests++;
    if (rdata_o !== 32'h44332211 || rdata_o !== e.word) begin
      n_fail++;
      $display("FAIL basic_rdata: got %h expected 44332211", rdata_o);
    end
    n_tests++;
    if (hdr_cap !== {OPC, 24'h200010}) begin
      n_fail++;
      $display("FAIL basic_mosi: got %h expected %h", hdr_cap, {OPC, 24'h200010});
    end
`ifdef SPI_FLASH_FASTREAD_EN
    n_tests++;
    if (dummy_cap !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_dummy: got %h expected 00", dummy_cap);
    end
`endif
    n_tests++;
    if (last_rises !== NBITS) begin
      n_fail++;
      $display("FAIL basic_sck_count: got %0d expected %0d", last_rises, NBITS);
    end
    @(posedge clk_i); #1;
    n_tests++;
    if ({rvalid_o, ready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_after_done: rvalid,ready=%b expected 00", {rvalid_o, ready_o});
    end
    @(posedge clk_i); #1;
    n_tests++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready_return: got %b expected 1", ready_o);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      if (rvalid_o) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL basic_single_pulse: extra rvalid cycles %0d expected 0", extra);
    end
  endtask

  task automatic test_align_wrap();
    exp_t e;
    int   cyc;
    issue(24'hE00003);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    wait_rvalid(cyc);
    n_tests++;
    if (rvalid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_rvalid: got %b expected 1 after %0d cycles", rvalid_o, cyc);
    end
    pop_exp(e);
    n_tests++;
    if (hdr_cap !== {OPC, 24'h000000}) begin
      n_fail++;
      $display("FAIL wrap_mosi: got %h expected %h", hdr_cap, {OPC, 24'h000000});
    end
    n_tests++;
    if (rdata_o !== e.word) begin
      n_fail++;
      $display("FAIL wrap_rdata: got %h expected %h", rdata_o, e.word);
    end
    repeat (CS_HIGH_MIN + 1) @(posedge clk_i);
    #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    int   cs_hi;
    issue(24'h000000);
    @(posedge clk_i); #1;
    issue(24'h000004);
    wait_rvalid(cyc);
    pop_exp(e);
    n_tests++;
    if (rvalid_o !== 1'b1 || rdata_o !== e.word) begin
      n_fail++;
      $display("FAIL b2b_first: rvalid=%b rdata=%h expected 1/%h", rvalid_o, rdata_o, e.word);
    end
    cs_hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (cs_o) cs_hi++;
      else break;
    end
    req_i = 1'b0;
    n_tests++;
    if (cs_hi !== CS_HIGH_MIN + 1) begin
      n_fail++;
      $display("FAIL b2b_cs_gap: got %0d cycles expected %0d", cs_hi, CS_HIGH_MIN + 1);
    end
    wait_rvalid(cyc);
    pop_exp(e);
    n_tests++;
    if (rvalid_o !== 1'b1 || rdata_o !== e.word) begin
      n_fail++;
      $display("FAIL b2b_second: rvalid=%b rdata=%h expected 1/%h", rvalid_o, rdata_o, e.word);
    end
    n_tests++;
    if (hdr_cap !== {OPC, 24'h200004}) begin
      n_fail++;
      $display("FAIL b2b_mosi: got %h expected %h", hdr_cap, {OPC, 24'h200004});
    end
    repeat (CS_HIGH_MIN + 1) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc;
    issue(24'h000020);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    n_tests++;
    if ({cs_o, sck_o, sdo_o, rvalid_o, ready_o} !== 5'b10001) begin
      n_fail++;
      $display("FAIL rstmid_pads: cs,sck,sdo,rvalid,ready=%b expected 10001", {cs_o, sck_o, sdo_o, rvalid_o, ready_o});
    end
    n_tests++;
    if (rdata_o !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_rdata: got %h expected 00000000", rdata_o);
    end
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    issue(24'h000014);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    wait_rvalid(cyc);
    pop_exp(e);
    n_tests++;
    if (rvalid_o !== 1'b1 || rdata_o !== e.word) begin
      n_fail++;
      $display("FAIL rstmid_reread: rvalid=%b rdata=%h expected 1/%h", rvalid_o, rdata_o, e.word);
    end
    n_tests++;
    if (hdr_cap !== {OPC, 24'h200014}) begin
      n_fail++;
      $display("FAIL rstmid_mosi: got %h expected %h", hdr_cap, {OPC, 24'h200014});
    end
    repeat (CS_HIGH_MIN + 1) @(posedge clk_i);
    #1;
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   cyc;
    int   cs_low;
    int   pulses;
    issue(24'h000030);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (HDR * 4 + 8) @(posedge clk_i);
    #1;
    req_i  = 1'b1;
    addr_i = 24'h000008;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    n_tests++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: got %b expected 0", ready_o);
    end
    wait_rvalid(cyc);
    pop_exp(e);
    n_tests++;
    if (rvalid_o !== 1'b1 || rdata_o !== e.word) begin
      n_fail++;
      $display("FAIL busy_word: rvalid=%b rdata=%h expected 1/%h", rvalid_o, rdata_o, e.word);
    end
    cs_low = 0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i); #1;
      if (!cs_o) cs_low++;
      if (rvalid_o) pulses++;
    end
    n_tests++;
    if (cs_low !== 0 || pulses !== 0) begin
      n_fail++;
      $display("FAIL busy_no_second: cs_low=%0d rvalid=%0d expected 0/0", cs_low, pulses);
    end
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL busy_scoreboard: %0d entries left expected 0", exp_q.size());
    end
  endtask

  task automatic test_sck_idle();
    n_tests++;
    if (sck_hi_edges !== 0) begin
      n_fail++;
      $display("FAIL sck_while_cs_high: got %0d edges expected 0", sck_hi_edges);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_align_wrap();
    test_back_to_back();
    test_reset_mid();
    test_busy_ignore();
    test_sck_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_flash_rd_ctrl.md
# spi_flash_rd_ctrl

Read-only SPI flash controller that sequences single-word read transactions to the external boot/data flash for the cv32e40x SoC. It accepts a word-read request from the SoC bus side, drives chip-select, SPI clock and MOSI through the command, address and data phases, and returns the assembled 32-bit word with a one-cycle valid pulse. It sits between the SoC interconnect and the `sck`/`sdo`/`sdi`/`cs` pads.

## Interface
Parameters:
- CLK_DIV, 2, SCK half-period in clk_i cycles; legal values are ≥1.
- ADDR_OFFSET, 24'h200000, flash byte offset added to every request address.
- CS_HIGH_MIN, 2, minimum number of clk_i cycles that cs_o stays high between transactions; legal values are ≥1.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  read request
- addr_i  in  24  byte address; bits [1:0] are ignored
- ready_o  out  1  controller idle; a request is accepted when req_i && ready_o
- rdata_o  out  32  read word, little-endian
- rvalid_o  out  1  one-cycle pulse; rdata_o is valid while it is high
- sck_o  out  1  SPI clock, mode 0
- sdo_o  out  1  MOSI
- sdi_i  in  1  MISO
- cs_o  out  1  chip select, active-low

## Operation
- FSM states: IDLE, SHIFT_CMD, SHIFT_ADDR, DUMMY (present only with the configuration macro), SHIFT_DATA, DONE, GAP.
- IDLE: ready_o=1. On acceptance, the controller latches the physical address `{addr_i[23:2],2'b00} + ADDR_OFFSET`. The sum wraps modulo 2^24. The FSM then moves to SHIFT_CMD.
- SHIFT_CMD: sends 8 bits MSB-first, opcode 8'h03 (8'h0B with the macro).
- SHIFT_ADDR: sends 24 address bits MSB-first.
- DUMMY: 8 SCK cycles with sdo_o=0.
- SHIFT_DATA: captures 32 bits. Byte k (k=0..3, in arrival order) goes to rdata_o[8k+7:8k]. Within each byte the first bit received is the MSB.
- DONE: cs_o goes high and rvalid_o pulses. rdata_o holds its value until the next DONE.
- GAP: cs_o stays high for CS_HIGH_MIN cycles, then the FSM returns to IDLE.
- req_i is ignored whenever ready_o=0. No queueing.
- Reset (including mid-transfer) forces:
  - cs_o=1, sck_o=0, sdo_o=0
  - rvalid_o=0, rdata_o=0
  - ready_o=1, FSM=IDLE
- A partial word is never returned.

## Timing
- NBITS = 64 (72 with the macro). TSCK = 2·CLK_DIV clk cycles.
- Acceptance edge T0: at T0+1, cs_o=0, ready_o=0, and sdo_o carries command bit 7.
- SCK edges:
  - sck_o rises CLK_DIV cycles after each bit is driven.
  - It falls CLK_DIV cycles later.
  - The next sdo_o bit changes on the same clk edge that lowers sck_o.
- sdi_i sampling: sampled on the clk edge that raises sck_o, data phase only.
- End of transfer, at T0+1+NBITS·TSCK (the last falling SCK edge):
  - cs_o=1, sck_o=0, rvalid_o=1, all on the same edge.
- ready_o returns to 1 at T0+1+NBITS·TSCK+CS_HIGH_MIN.
- Latency request-to-rvalid with CLK_DIV=2: 257 cycles (289 with the macro).
- Back-to-back: a request held high is accepted on the first cycle ready_o=1. cs_o stays high for exactly CS_HIGH_MIN+1 cycles between transactions.
- sck_o idles low. No SCK edges occur while cs_o=1.

## Configuration
- SPI_FLASH_FASTREAD_EN defined:
  - opcode 8'h0B
  - DUMMY state inserted after the address phase (8 SCK cycles)
  - NBITS=72
- Not defined:
  - opcode 8'h03
  - no DUMMY state
  - NBITS=64
- Both builds share the same ports and handshake.

## Test plan
- **Basic read:** addr_i=24'h000010, flash bytes at 0x200010..13 = 11 22 33 44 -> MOSI shows 03 20 00 10; rdata_o=32'h44332211; rvalid_o pulses exactly once, 257 cycles after acceptance (CLK_DIV=2).
- **Alignment/wrap:** addr_i=24'hE00003 -> physical 24'h000000 is sent on MOSI (low bits dropped, sum wrapped).
- **Back-to-back:** req_i held high for addr 0x0, then 0x4 -> two rvalid pulses; cs_o high for exactly 3 cycles between them; the second word is the bytes at 0x200004..07.
- **Reset mid-transfer:** assert rst_i in the address phase -> cs_o=1, sck_o=0, rvalid_o=0 immediately (asynchronously); a new request after release returns correct data.
- **Request ignored while busy:** pulse req_i with addr 0x8 during SHIFT_DATA -> no second transaction starts; the first word returns unchanged.
- **Fast-read build:** with SPI_FLASH_FASTREAD_EN, addr 0x10 -> MOSI shows 0B 20 00 10 then 8 zero bits; data matches the basic-read test; latency is 289 cycles.
